// File: rtl/uart_pkg.sv
// uart_pkg: shared UART stream width and data word type
package uart_pkg;
   localparam int DATA_W = 8;
   typedef logic [DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: dual-port register array, synchronous write, combinational read
module uart_fifo_mem #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_stream_fifo.sv
// uart_stream_fifo: valid/ready byte FIFO between UART stream endpoints with sticky overrun
module uart_stream_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overrun,
   input  logic                       overrun_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  full, empty, wr_fire, rd_fire;
   assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty     = wr_ptr == rd_ptr;
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign wr_fire   = rstn && in_valid && in_ready;
   assign rd_fire   = rstn && out_valid && out_ready;
   assign out_data  = out_valid ? rdata : '0;
   uart_fifo_mem #(.W(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (in_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr + PW'(wr_fire);
         rd_ptr  <= rd_ptr + PW'(rd_fire);
         count   <= count + CW'(wr_fire) - CW'(rd_fire);
         overrun <= (in_valid && !in_ready) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
      end
   end
endmodule

// File: tb/tb_uart_stream_fifo.sv
// tb_uart_stream_fifo: queue-scoreboard bench for uart_stream_fifo
module tb_uart_stream_fifo;
   localparam int DEPTH = 16;
   logic       clk, rstn, in_valid, in_ready, out_valid, out_ready, overrun, overrun_clr;
   logic [7:0] in_data, out_data;
   logic [4:0] count;
   logic [7:0] q[$];
   logic       ov_m, chk_en, rd_m, wr_m, ovs_m;
   int         n_chk, n_pass;
   uart_stream_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (chk_en) begin
         check("mon_count", count, q.size());
         check("mon_in_ready", in_ready, q.size() < DEPTH);
         check("mon_out_valid", out_valid, q.size() != 0);
         check("mon_overrun", overrun, ov_m);
         if (q.size() != 0) check("mon_out_data", out_data, q[0]);
      end
      if (!rstn) begin
         q.delete();
         ov_m = 0;
      end else begin
         rd_m  = q.size() != 0 && out_ready;
         wr_m  = in_valid && q.size() < DEPTH;
         ovs_m = in_valid && q.size() == DEPTH;
         if (rd_m) q.delete(0);
         if (wr_m) q.push_back(in_data);
         ov_m = ovs_m ? 1'b1 : overrun_clr ? 1'b0 : ov_m;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      n_chk = 0; n_pass = 0; chk_en = 0; ov_m = 0;
      rstn = 0; in_valid = 1; in_data = 8'hAA; out_ready = 0; overrun_clr = 0;
      cyc();
      chk_en = 1;
      cyc();
      rstn = 1; in_valid = 0;
      cyc();
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_overrun", overrun, 0);
      check("rst_out_data", out_data, 0);
      in_data = 8'h5A; in_valid = 1;
      cyc();
      in_valid = 0;
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 8'h5A);
      check("single_count", count, 1);
      out_ready = 1;
      cyc();
      out_ready = 0;
      check("single_drain_valid", out_valid, 0);
      check("single_drain_count", count, 0);
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i); in_valid = 1;
         cyc();
      end
      in_valid = 0;
      check("fill_ready", in_ready, 0);
      check("fill_count", count, 16);
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         check("drain_order", out_data, i);
         cyc();
      end
      out_ready = 0;
      check("half_count", count, 8);
      for (int i = 16; i < 24; i++) begin
         in_data = 8'(i); in_valid = 1;
         cyc();
      end
      in_valid = 0;
      check("wrap_count", count, 16);
      out_ready = 1;
      for (int i = 8; i < 24; i++) begin
         check("wrap_order", out_data, i);
         cyc();
      end
      out_ready = 0;
      check("empty_count", count, 0);
      for (int i = 0; i < 5; i++) begin
         in_data = 8'(8'h20 + i); in_valid = 1;
         cyc();
      end
      for (int i = 0; i < 20; i++) begin
         in_data = 8'(8'h25 + i); in_valid = 1; out_ready = 1;
         check("sim_data", out_data, 8'h20 + i);
         cyc();
         check("sim_count", count, 5);
      end
      out_ready = 0;
      for (int i = 0; i < 11; i++) begin
         in_data = 8'(8'h40 + i); in_valid = 1;
         cyc();
      end
      in_valid = 0;
      check("full_count", count, 16);
      in_data = 8'hEE; in_valid = 1; out_ready = 1;
      cyc();
      in_valid = 0; out_ready = 0;
      check("ovr_set", overrun, 1);
      check("ovr_ready", in_ready, 1);
      check("ovr_count", count, 15);
      overrun_clr = 1;
      cyc();
      overrun_clr = 0;
      check("ovr_clr", overrun, 0);
      in_data = 8'h77; in_valid = 1;
      cyc();
      check("refill_count", count, 16);
      overrun_clr = 1;
      cyc();
      check("ovr_priority", overrun, 1);
      in_valid = 0;
      cyc();
      overrun_clr = 0;
      check("ovr_clr2", overrun, 0);
      out_ready = 1;
      repeat (9) cyc();
      out_ready = 0;
      check("mid_count", count, 7);
      rstn = 0;
      cyc();
      rstn = 1;
      check("mid_rst_count", count, 0);
      check("mid_rst_valid", out_valid, 0);
      in_data = 8'h11; in_valid = 1;
      cyc();
      in_valid = 0;
      check("post_rst_data", out_data, 8'h11);
      out_ready = 1;
      cyc();
      out_ready = 0;
      check("post_rst_empty", count, 0);
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
